// File: rtl/kronos_ex.sv
// -----------------------------------------------------------------------------
// kronos_ex -- execute stage of the Kronos RV32I pipeline.
//
// Takes decoded operands from decode and computes two results:
//   result1 : ALU result (arithmetic, logic, compare flag or shift)
//   result2 : address/target sum op3 + op4
// Both results and the control fields are registered into one output slot
// that write-back drains.
//
// Shifts by a nonzero amount use a 1-bit-per-cycle serial shifter. While a
// shift runs the stage sits in SHIFT and holds decode off. Every other
// operation completes in a single cycle.
//
// Handshakes (both sides follow the same rule):
//   A transfer happens on a rising clk edge where valid && ready are both
//   high. The producer holds its valid and payload stable until that
//   transfer happens. ready never depends on valid.
//   decode -> ex : decode_vld / decode_rdy
//   ex -> wb     : execute_vld / execute_rdy
//
// Ports:
//   clk, rstz            clock; asynchronous active-low reset
//   flush                kills the output slot and any shift in progress
//   decode_vld/rdy       input handshake
//   op1, op2             ALU operands; shift amount is op2[4:0]
//   op3, op4             adder operands
//   aluop                ALU operation select
//   rd ... data_size     control fields, passed through unchanged
//   execute_vld/rdy      output handshake
//   ex_*                 registered output payload
// -----------------------------------------------------------------------------
module kronos_ex (
    input  logic        clk,
    input  logic        rstz,
    input  logic        flush,

    input  logic        decode_vld,
    output logic        decode_rdy,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] op3,
    input  logic [31:0] op4,
    input  logic [3:0]  aluop,
    input  logic [4:0]  rd,
    input  logic        rd_write,
    input  logic        branch,
    input  logic        branch_cond,
    input  logic        ld,
    input  logic        st,
    input  logic        data_uns,
    input  logic [1:0]  data_size,
    input  logic        is_illegal,

    output logic        execute_vld,
    input  logic        execute_rdy,
    output logic [31:0] ex_result1,
    output logic [31:0] ex_result2,
    output logic [4:0]  ex_rd,
    output logic        ex_rd_write,
    output logic        ex_branch,
    output logic        ex_branch_cond,
    output logic        ex_ld,
    output logic        ex_st,
    output logic        ex_data_uns,
    output logic [1:0]  ex_data_size,
    output logic        ex_is_illegal
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_EQ   = 4'd10;
    localparam logic [3:0] OP_NE   = 4'd11;
    localparam logic [3:0] OP_GE   = 4'd12;
    localparam logic [3:0] OP_GEU  = 4'd13;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Control fields travel as one bundle so the holding registers and
    // the output slot stay in step.
    typedef struct packed {
        logic [4:0] rd;
        logic       rd_write;
        logic       branch;
        logic       branch_cond;
        logic       ld;
        logic       st;
        logic       data_uns;
        logic [1:0] data_size;
        logic       is_illegal;
    } ctrl_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e      state_q,   state_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic [31:0] shreg_q,   shreg_d;
    logic        sh_right_q, sh_right_d;  // 1: SRL/SRA, 0: SLL
    logic        sh_arith_q, sh_arith_d;  // 1: SRA (fill with bit 31)
    logic [31:0] hold_r2_q, hold_r2_d;
    ctrl_t       hold_ctrl_q, hold_ctrl_d;

    logic        vld_q,     vld_d;
    logic [31:0] r1_q,      r1_d;
    logic [31:0] r2_q,      r2_d;
    ctrl_t       ctrl_q,    ctrl_d;

    // -------------------------------------------------------------------------
    // Single-cycle ALU
    // -------------------------------------------------------------------------
    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic        lt_s;
    logic        lt_u;
    logic        eq;
    logic [31:0] alu_res;
    logic [31:0] sum2;
    ctrl_t       ctrl_in;

    always_comb begin
        add_res = op1 + op2;
        sub_res = op1 - op2;
        lt_s    = $signed(op1) < $signed(op2);
        lt_u    = op1 < op2;
        eq      = (op1 == op2);
        sum2    = op3 + op4;

        alu_res = add_res;
        if (!is_illegal) begin
            case (aluop)
                OP_SUB:  alu_res = sub_res;
                OP_AND:  alu_res = op1 & op2;
                OP_OR:   alu_res = op1 | op2;
                OP_XOR:  alu_res = op1 ^ op2;
                OP_SLT:  alu_res = {31'd0, lt_s};
                OP_SLTU: alu_res = {31'd0, lt_u};
                // Shifts only reach this path with a zero shift amount.
                OP_SLL,
                OP_SRL,
                OP_SRA:  alu_res = op1;
                OP_EQ:   alu_res = {31'd0, eq};
                OP_NE:   alu_res = {31'd0, ~eq};
                OP_GE:   alu_res = {31'd0, ~lt_s};
                OP_GEU:  alu_res = {31'd0, ~lt_u};
                default: alu_res = add_res;
            endcase
        end

        ctrl_in.rd          = rd;
        ctrl_in.rd_write    = rd_write;
        ctrl_in.branch      = branch;
        ctrl_in.branch_cond = branch_cond;
        ctrl_in.ld          = ld;
        ctrl_in.st          = st;
        ctrl_in.data_uns    = data_uns;
        ctrl_in.data_size   = data_size;
        ctrl_in.is_illegal  = is_illegal;
    end

    // -------------------------------------------------------------------------
    // Handshake and control
    // -------------------------------------------------------------------------
    logic slot_free;
    logic accept;
    logic is_shift_op;
    logic start_shift;
    logic load_single;
    logic shift_done;

    always_comb begin
        slot_free   = ~vld_q | execute_rdy;
        decode_rdy  = (state_q == IDLE) & slot_free;
        accept      = decode_vld & decode_rdy;
        is_shift_op = (aluop == OP_SLL) | (aluop == OP_SRL) | (aluop == OP_SRA);
        // Illegal instructions never enter the serial shifter.
        start_shift = accept & is_shift_op & ~is_illegal & (op2[4:0] != 5'd0);
        load_single = accept & ~start_shift;
        shift_done  = (state_q == SHIFT) & (cnt_q == 5'd0) & slot_free;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        sh_right_d  = sh_right_q;
        sh_arith_d  = sh_arith_q;
        hold_r2_d   = hold_r2_q;
        hold_ctrl_d = hold_ctrl_q;
        vld_d       = vld_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        ctrl_d      = ctrl_q;

        if (flush) begin
            // Anything accepted this cycle is dropped along with the slot.
            vld_d   = 1'b0;
            state_d = IDLE;
            cnt_d   = 5'd0;
        end else begin
            if (start_shift) begin
                state_d     = SHIFT;
                cnt_d       = op2[4:0];
                shreg_d     = op1;
                sh_right_d  = (aluop != OP_SLL);
                sh_arith_d  = (aluop == OP_SRA);
                hold_r2_d   = sum2;
                hold_ctrl_d = ctrl_in;
            end else if (state_q == SHIFT && cnt_q != 5'd0) begin
                cnt_d = cnt_q - 5'd1;
                if (sh_right_q)
                    shreg_d = {sh_arith_q & shreg_q[31], shreg_q[31:1]};
                else
                    shreg_d = {shreg_q[30:0], 1'b0};
            end

            if (load_single) begin
                vld_d  = 1'b1;
                r1_d   = alu_res;
                r2_d   = sum2;
                ctrl_d = ctrl_in;
            end else if (shift_done) begin
                vld_d   = 1'b1;
                r1_d    = shreg_q;
                r2_d    = hold_r2_q;
                ctrl_d  = hold_ctrl_q;
                state_d = IDLE;
            end else if (vld_q && execute_rdy) begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            shreg_q     <= 32'd0;
            sh_right_q  <= 1'b0;
            sh_arith_q  <= 1'b0;
            hold_r2_q   <= 32'd0;
            hold_ctrl_q <= '0;
            vld_q       <= 1'b0;
            r1_q        <= 32'd0;
            r2_q        <= 32'd0;
            ctrl_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            sh_right_q  <= sh_right_d;
            sh_arith_q  <= sh_arith_d;
            hold_r2_q   <= hold_r2_d;
            hold_ctrl_q <= hold_ctrl_d;
            vld_q       <= vld_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            ctrl_q      <= ctrl_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign execute_vld    = vld_q;
    assign ex_result1     = r1_q;
    assign ex_result2     = r2_q;
    assign ex_rd          = ctrl_q.rd;
    assign ex_rd_write    = ctrl_q.rd_write;
    assign ex_branch      = ctrl_q.branch;
    assign ex_branch_cond = ctrl_q.branch_cond;
    assign ex_ld          = ctrl_q.ld;
    assign ex_st          = ctrl_q.st;
    assign ex_data_uns    = ctrl_q.data_uns;
    assign ex_data_size   = ctrl_q.data_size;
    assign ex_is_illegal  = ctrl_q.is_illegal;

endmodule
